// File: rtl/led_ctrl_pkg.sv
// Shared constants for the bus-mapped LED controller: register offsets,
// CTRL bit positions and reset values.
package led_ctrl_pkg;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLINK_BIT = 1;
  localparam int CTRL_INV_BIT   = 2;

  localparam logic [7:0] CTRL_MASK = 8'h07;
  localparam logic [7:0] CTRL_RST  = 8'h01;
  localparam logic [7:0] DUTY_RST  = 8'hFF;

  // Control registers sit directly above the NB data bytes.
  function automatic logic [7:0] ofs_ctrl(input int nb);
    return 8'(nb);
  endfunction

  function automatic logic [7:0] ofs_duty(input int nb);
    return 8'(nb + 1);
  endfunction

  function automatic logic [7:0] ofs_period(input int nb);
    return 8'(nb + 2);
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Blink phase generator: prescaled tick, half-period counter and phase flag.
// PERIOD of zero pins the phase high.
module led_blink_timer #(
  parameter int PRESCALE = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PERIOD,
  input  logic       clear,
  output logic       phase
);

  localparam int TW = $clog2(PRESCALE);
  localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);

  logic [TW-1:0] tick_cnt_reg;
  logic [7:0]    blink_cnt_reg;
  logic          phase_reg;
  logic          tick;

  assign tick  = (tick_cnt_reg == TICK_LAST);
  assign phase = phase_reg;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      tick_cnt_reg  <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
      if (PERIOD == 8'd0) begin
        blink_cnt_reg <= '0;
        phase_reg     <= 1'b1;
      end else if (tick) begin
        if (({1'b0, blink_cnt_reg} + 9'd1) == {1'b0, PERIOD}) begin
          blink_cnt_reg <= '0;
          phase_reg     <= ~phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_led_pwm_ctrl.sv
// Bus-mapped LED peripheral: NB data bytes plus CTRL/DUTY/PERIOD registers,
// readable over the tristate bus, with PWM dimming and prescaled blink.
module bus_led_pwm_ctrl
  import led_ctrl_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC0,
  parameter int         NUM_LEDS  = 16,
  parameter int         PRESCALE  = 50000
) (
  input  logic                CLK,
  input  logic                RESET,
  inout  wire  [7:0]          BUS_DATA,
  input  logic [7:0]          BUS_ADDR,
  input  logic                BUS_WE,
  output logic [NUM_LEDS-1:0] LEDs
);

  localparam int NB = NUM_LEDS / 8;
  localparam logic [7:0] OFS_CTRL   = ofs_ctrl(NB);
  localparam logic [7:0] OFS_DUTY   = ofs_duty(NB);
  localparam logic [7:0] OFS_PERIOD = ofs_period(NB);
  // Nine-bit window bounds so a window near 8'hFF never wraps to low addresses.
  localparam logic [8:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [8:0] WIN_HI = WIN_LO + 9'(NB + 2);

  logic                hit, wr_hit, rd_hit;
  logic [7:0]          offset;
  logic [NUM_LEDS-1:0] data_all;
  logic [7:0]          ctrl_reg, duty_reg, period_reg, pwm_cnt_reg;
  logic [7:0]          rd_data_reg, rd_next;
  logic                drive_en_reg;
  logic [NUM_LEDS-1:0] leds_reg;
  logic                pwm_on, phase, led_gate, period_clear;

  assign hit    = ({1'b0, BUS_ADDR} >= WIN_LO) && ({1'b0, BUS_ADDR} <= WIN_HI);
  assign wr_hit = hit && BUS_WE;
  assign rd_hit = hit && !BUS_WE;
  assign offset = BUS_ADDR - BASE_ADDR;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_data
      logic [7:0] byte_reg;
      logic       byte_we;
      assign byte_we = wr_hit && (offset == 8'(gi));
      always_ff @(posedge CLK) begin
        if (RESET)        byte_reg <= 8'h00;
        else if (byte_we) byte_reg <= BUS_DATA;
      end
      assign data_all[8*gi +: 8] = byte_reg;
    end
  endgenerate

  always_comb begin
    rd_next = 8'h00;
    for (int i = 0; i < NB; i++)
      if (offset == 8'(i)) rd_next = data_all[8*i +: 8];
    if (offset == OFS_CTRL)   rd_next = ctrl_reg;
    if (offset == OFS_DUTY)   rd_next = duty_reg;
    if (offset == OFS_PERIOD) rd_next = period_reg;
  end

  assign period_clear = wr_hit && (offset == OFS_PERIOD);
  assign pwm_on   = (duty_reg == 8'hFF) || (pwm_cnt_reg < duty_reg);
  assign led_gate = ctrl_reg[CTRL_EN_BIT] && pwm_on &&
                    (phase || !ctrl_reg[CTRL_BLINK_BIT]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_reg     <= CTRL_RST;
      duty_reg     <= DUTY_RST;
      period_reg   <= 8'h00;
      pwm_cnt_reg  <= 8'h00;
      rd_data_reg  <= 8'h00;
      drive_en_reg <= 1'b0;
      leds_reg     <= '0;
    end else begin
      pwm_cnt_reg  <= pwm_cnt_reg + 8'd1;
      drive_en_reg <= rd_hit;
      if (rd_hit) rd_data_reg <= rd_next;
      if (wr_hit) begin
        if (offset == OFS_CTRL)   ctrl_reg   <= BUS_DATA & CTRL_MASK;
        if (offset == OFS_DUTY)   duty_reg   <= BUS_DATA;
        if (offset == OFS_PERIOD) period_reg <= BUS_DATA;
      end
      leds_reg <= (data_all & {NUM_LEDS{led_gate}}) ^ {NUM_LEDS{ctrl_reg[CTRL_INV_BIT]}};
    end
  end

  led_blink_timer #(
    .PRESCALE(PRESCALE)
  ) u_blink (
    .CLK   (CLK),
    .RESET (RESET),
    .PERIOD(period_reg),
    .clear (period_clear),
    .phase (phase)
  );

  assign BUS_DATA = drive_en_reg ? rd_data_reg : 8'hzz;
  assign LEDs     = leds_reg;

endmodule

// File: tb/tb_bus_led_pwm_ctrl.sv
// Bench for bus_led_pwm_ctrl: directed scenarios with literal expectations plus
// random bus traffic, all checked every cycle against a behavioural model.
module tb_bus_led_pwm_ctrl;

  localparam int PRE = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  BUS_ADDR = 8'h00;
  logic        BUS_WE = 1'b0;
  logic [15:0] LEDs;
  wire  [7:0]  BUS_DATA;
  logic        tb_drive = 1'b0;
  logic [7:0]  tb_data = 8'h00;

  int errors = 0;
  int checks = 0;

  assign BUS_DATA = tb_drive ? tb_data : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup (BUS_DATA[gi]);
  end

  bus_led_pwm_ctrl #(
    .BASE_ADDR(8'hC0),
    .NUM_LEDS (16),
    .PRESCALE (PRE)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .BUS_DATA(BUS_DATA),
    .BUS_ADDR(BUS_ADDR),
    .BUS_WE  (BUS_WE),
    .LEDs    (LEDs)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: register contents plus elapsed-cycle counts.
  logic [7:0]  m_data [2];
  logic [7:0]  m_ctrl, m_duty, m_period;
  int          m_cycles, m_since;
  logic [15:0] exp_leds = 16'h0;
  logic        exp_drive = 1'b0;
  logic [7:0]  exp_rd = 8'h00;
  logic [7:0]  exp_bus;
  bit          model_valid = 1'b0;
  bit          m_pwm_on, m_ph, m_gate, m_hit;
  int          m_off;

  function automatic logic [7:0] model_reg(input int o);
    case (o)
      0: return m_data[0];
      1: return m_data[1];
      2: return m_ctrl;
      3: return m_duty;
      default: return m_period;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      m_data[0] = 8'h00; m_data[1] = 8'h00;
      m_ctrl = 8'h01; m_duty = 8'hFF; m_period = 8'h00;
      m_cycles = 0; m_since = 0;
      exp_leds = 16'h0; exp_drive = 1'b0; exp_rd = 8'h00;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_pwm_on = (m_duty == 8'hFF) || ((m_cycles % 256) < int'(m_duty));
      m_ph     = (m_period == 8'h00) || ((((m_since / PRE) / int'(m_period)) % 2) == 0);
      m_gate   = m_ctrl[0] && m_pwm_on && (m_ph || !m_ctrl[1]);
      exp_leds = ({m_data[1], m_data[0]} & {16{m_gate}}) ^ {16{m_ctrl[2]}};
      m_off    = int'(BUS_ADDR) - 192;
      m_hit    = (m_off >= 0) && (m_off <= 4);
      exp_drive = m_hit && !BUS_WE;
      if (exp_drive) exp_rd = model_reg(m_off);
      m_cycles++;
      m_since++;
      if (m_hit && BUS_WE) begin
        case (m_off)
          0: m_data[0] = tb_data;
          1: m_data[1] = tb_data;
          2: m_ctrl = tb_data & 8'h07;
          3: m_duty = tb_data;
          default: begin m_period = tb_data; m_since = 0; end
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison, shortly after each active edge.
  always @(posedge CLK) begin
    #2;
    if (model_valid) begin
      checks++;
      if (LEDs !== exp_leds) begin
        errors++;
        $display("FAIL leds t=%0t got=%h exp=%h", $time, LEDs, exp_leds);
      end
      exp_bus = exp_drive ? exp_rd : (tb_drive ? tb_data : 8'hFF);
      checks++;
      if (BUS_DATA !== exp_bus) begin
        errors++;
        $display("FAIL bus_data t=%0t got=%h exp=%h", $time, BUS_DATA, exp_bus);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a; BUS_WE = 1'b1; tb_data = d; tb_drive = 1'b1;
    @(negedge CLK);
    tb_drive = 1'b0; BUS_WE = 1'b0; BUS_ADDR = 8'h00;
    $display("wr addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    BUS_ADDR = a; BUS_WE = 1'b0;
    @(negedge CLK);
    v = BUS_DATA;
    BUS_ADDR = 8'h00;
    @(negedge CLK);
    $display("rd addr=%h data=%h", a, v);
  endtask

  task automatic count_lit(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      if (LEDs != 16'h0) cnt++;
    end
  endtask

  logic [7:0]  v, a, d;
  logic [15:0] v16;
  int          cnt, gap, r;

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    check("rst_leds", 32'(LEDs), 32'h0);
    check("idle_bus", 32'(BUS_DATA), 32'hFF);
    rd(8'hC0, v); check("rst_c0", 32'(v), 32'h00);
    rd(8'hC1, v); check("rst_c1", 32'(v), 32'h00);
    rd(8'hC2, v); check("rst_ctrl", 32'(v), 32'h01);
    rd(8'hC3, v); check("rst_duty", 32'(v), 32'hFF);
    rd(8'hC4, v); check("rst_period", 32'(v), 32'h00);

    wr(8'hC0, 8'hA5);
    wr(8'hC1, 8'h3C);
    check("leds_latency", 32'(LEDs), 32'h00A5);
    @(negedge CLK);
    check("leds_3ca5", 32'(LEDs), 32'h3CA5);
    rd(8'hC0, v); check("rdback_c0", 32'(v), 32'hA5);

    wr(8'hC3, 8'h40);
    rd(8'hC3, v); check("wr_rd_b2b", 32'(v), 32'h40);
    count_lit(256, cnt); check("duty40_on", 32'(cnt), 32'd64);
    wr(8'hC3, 8'h00);
    @(negedge CLK);
    count_lit(256, cnt); check("duty0_on", 32'(cnt), 32'd0);
    wr(8'hC3, 8'hFF);
    @(negedge CLK);
    count_lit(256, cnt); check("dutyff_on", 32'(cnt), 32'd256);

    wr(8'hC4, 8'd3);
    wr(8'hC2, 8'h03);
    for (int pass = 0; pass < 2; pass++) begin
      v16 = LEDs; gap = 0;
      while (LEDs == v16 && gap < 100) begin
        @(negedge CLK);
        gap++;
      end
    end
    check("blink_gap", 32'(gap), 32'd12);
    wr(8'hC4, 8'd0);
    @(negedge CLK);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (LEDs != 16'h3CA5) cnt++;
    end
    check("period0_steady", 32'(cnt), 32'd0);

    wr(8'hC2, 8'h04);
    @(negedge CLK);
    check("inv_leds", 32'(LEDs), 32'hFFFF);
    wr(8'hC5, 8'h77);
    rd(8'hC5, v); check("oow_rd_z", 32'(v), 32'hFF);
    rd(8'hC0, v); check("oow_c0", 32'(v), 32'hA5);
    rd(8'hC1, v); check("oow_c1", 32'(v), 32'h3C);
    rd(8'hC2, v); check("oow_ctrl", 32'(v), 32'h04);
    rd(8'hC3, v); check("oow_duty", 32'(v), 32'hFF);
    rd(8'hC4, v); check("oow_period", 32'(v), 32'h00);

    wr(8'hC3, 8'h40);
    BUS_ADDR = 8'hC3; BUS_WE = 1'b0;
    repeat (3) @(negedge CLK);
    check("held_rd", 32'(BUS_DATA), 32'h40);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_rel_bus", 32'(BUS_DATA), 32'hFF);
    check("rst_rel_leds", 32'(LEDs), 32'h0);
    RESET = 1'b0; BUS_ADDR = 8'h00;
    @(negedge CLK);
    $display("reset during held read of C3");
    rd(8'hC3, v); check("post_rst_duty", 32'(v), 32'hFF);
    rd(8'hC0, v); check("post_rst_c0", 32'(v), 32'h00);
    rd(8'hC2, v); check("post_rst_ctrl", 32'(v), 32'h01);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      a = 8'hBE + 8'($urandom_range(0, 9));
      d = (a == 8'hC4) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      if (r < 5) wr(a, d);
      else if (r < 8) rd(a, v);
      else if (r == 8) begin
        cnt = $urandom_range(1, 20);
        repeat (cnt) @(negedge CLK);
        $display("idle cycles=%0d", cnt);
      end else if ($urandom_range(0, 9) == 0) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        $display("reset pulse");
      end
    end
    repeat (4) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_led_pwm_ctrl.md
# bus_led_pwm_ctrl

Bus-mapped LED peripheral for the 8-bit processor bus: a parametrised successor to the fixed two-byte LED register block. It holds NUM_LEDS output bits in byte-wide registers and applies a global enable, an 8-bit PWM brightness and a prescaled blink mode. Every register is readable back over the tristate data bus. It sits on the shared bus alongside the other peripherals and drives the board LEDs directly.

## Interface
Parameters:
- BASE_ADDR, 8'hC0, first bus address of the register window.
- NUM_LEDS, 16, LED count; must be a multiple of 8 in the range 8..64. NB = NUM_LEDS/8.
- PRESCALE, 50000, clock cycles per blink tick; must be ≥ 2.

Ports:
- CLK  in  1  system clock. One clock domain.
- RESET  in  1  synchronous, active-high reset.
- BUS_DATA  inout  8  bidirectional data; high-Z unless this block is driving a read.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable; 1 = write, 0 = read.
- LEDs  out  NUM_LEDS  registered LED drive.

## Operation
- Window is BASE_ADDR .. BASE_ADDR+NB+2. A hit is BUS_ADDR inside the window, computed without 8-bit wrap (9-bit compare). Offset = BUS_ADDR − BASE_ADDR.
- Offsets 0..NB−1, DATA[k]: drives LEDs[8k+7:8k].
- Offset NB, CTRL: bit0 EN, bit1 BLINK_EN, bit2 INV. Bits 7:3 are ignored on write and read as 0.
- Offset NB+1, DUTY: brightness.
- Offset NB+2, PERIOD: blink half-period in ticks.
- Write: a hit with BUS_WE=1 at a rising edge loads BUS_DATA into the addressed register. Writing PERIOD also clears tick_cnt and blink_cnt and sets phase=1.
- Read: a hit with BUS_WE=0 at a rising edge registers the addressed value and sets drive_en. BUS_DATA = drive_en ? rd_data : 8'hZZ. drive_en clears at the first edge where there is no hit or BUS_WE=1.
- PWM: an 8-bit pwm_cnt free-runs 0..255 and wraps. pwm_on = (DUTY==8'hFF) | (pwm_cnt < DUTY). DUTY=0 means always off.
- Blink:
  - tick_cnt counts 0..PRESCALE−1; tick is asserted on the terminal count.
  - On each tick, blink_cnt increments. When blink_cnt+1 == PERIOD, blink_cnt returns to 0 and phase toggles.
  - PERIOD=0 means phase is held at 1.
- Output, registered: LEDs <= (DATA_all & {NUM_LEDS{EN & pwm_on & (phase | ~BLINK_EN)}}) ^ {NUM_LEDS{INV}}.
- Reset values: DATA=0, CTRL=8'h01, DUTY=8'hFF, PERIOD=0, pwm_cnt=0, tick_cnt=0, blink_cnt=0, phase=1, drive_en=0 (BUS_DATA high-Z), rd_data=0, LEDs=0.

## Timing
- Write at edge N: the register holds the new value after edge N. LEDs reflect it after edge N+1 (one-cycle output latency).
- Read: address sampled at edge N. BUS_DATA is valid from edge N until the edge after the address leaves the window. The processor samples at edge N+1.
- Write and read to the same register on back-to-back cycles: the read returns the new value.
- Write with BUS_WE=1: this block never drives BUS_DATA in the same or the following cycle once WE is seen.
- PWM period is 256 cycles. Blink full period is 2·PERIOD·PRESCALE cycles.
- RESET asserted mid-read releases BUS_DATA after that edge. Mid-blink, it restores phase=1 and zeroes all counters. RESET takes priority over a simultaneous write.
- Out-of-window accesses change no state.

## Structure
- Package led_ctrl_pkg:
  - offset constants (OFS_CTRL=NB, OFS_DUTY=NB+1, OFS_PERIOD=NB+2, as functions of NB);
  - CTRL bit indices;
  - reset constants (CTRL_RST=8'h01, DUTY_RST=8'hFF).
- Sub-module led_blink_timer (CLK, RESET, PRESCALE, PERIOD, clear → phase): contains tick_cnt, blink_cnt and phase.
- The PWM counter, register file and bus interface stay in the top module.

## Test plan
- Reset, then read offsets 0..NB+2 (NUM_LEDS=16) → 00, 00, 01, FF, 00. BUS_DATA is Z while idle. LEDs=0.
- Write 8'hA5 to C0 and 8'h3C to C1 → LEDs=16'h3CA5 exactly two edges after the C1 write. Readback C0=A5.
- Write DUTY=8'h40 → LEDs lit for exactly 64 of every 256 cycles. DUTY=0 → LEDs=0 throughout. DUTY=FF → steady.
- PRESCALE=4, write PERIOD=3 and CTRL=8'h03 → LEDs toggle every 12 cycles. Writing PERIOD=0 → steady on.
- Write CTRL=8'h04 (EN=0, INV=1) → LEDs=16'hFFFF. Writing to C5 (out of window) leaves all reads unchanged and BUS_DATA Z.
- Assert RESET during a held read of C3 → BUS_DATA Z after the edge, registers restored to reset values.
